// File: rtl/conv_job_scheduler_pkg.sv
// Shared state encoding, activation-mode constants and width helper for the
// convolution job scheduler.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACC,
    S_ACT,
    S_WRITE,
    S_FINISH
  } state_t;

  localparam logic [1:0] ACT_NONE   = 2'b00;
  localparam logic [1:0] ACT_RELU   = 2'b01;
  localparam logic [1:0] ACT_CORDIC = 2'b10;

  localparam int IMG_W_DEF   = 6;
  localparam int K_DEF       = 5;
  localparam int TIMEOUT_DEF = 255;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_job_scheduler_tap_counter.sv
// Nested row/column counter over an N x N window with explicit terminal
// compares; exposes current and next values so address stages can lead the count.
module conv_tap_counter
  import conv_pkg::*;
#(
  parameter int N = 5,
  parameter int W = cw(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_row,
  output logic [W-1:0] o_col,
  output logic [W-1:0] o_row_nxt,
  output logic [W-1:0] o_col_nxt,
  output logic         o_last
);

  logic [W-1:0] r_row;
  logic [W-1:0] r_col;
  logic         w_row_end;
  logic         w_col_end;

  assign w_row_end = (r_row == W'(N - 1));
  assign w_col_end = (r_col == W'(N - 1));
  assign o_last    = w_row_end && w_col_end;
  assign o_row     = r_row;
  assign o_col     = r_col;

  always_comb begin
    o_row_nxt = r_row;
    o_col_nxt = r_col;
    if (i_clr) begin
      o_row_nxt = '0;
      o_col_nxt = '0;
    end else if (i_en) begin
      if (w_col_end) begin
        o_col_nxt = '0;
        o_row_nxt = w_row_end ? '0 : r_row + W'(1);
      end else begin
        o_col_nxt = r_col + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= o_row_nxt;
      r_col <= o_col_nxt;
    end
  end

endmodule

// File: rtl/conv_job_scheduler.sv
// Convolution job sequencer: walks output pixels and kernel taps, handshakes
// taps into the MAC, runs the optional activation step and writes each result.
module conv_job_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int K       = K_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int OUT_W  = IMG_W - K + 1,
  localparam int IN_AW  = cw(IMG_W * IMG_W),
  localparam int W_AW   = cw(K * K),
  localparam int OUT_AW = cw(OUT_W * OUT_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_r,
  input  logic              load_wr,
  input  logic [1:0]        act_mode,
  input  logic              mac_ready,
  input  logic              acc_valid,
  input  logic              act_done,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic [1:0]        act_sel,
  output logic              act_start,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  localparam int KW = cw(K);
  localparam int PW = cw(OUT_W);
  localparam int TW = cw(TIMEOUT + 1);

  if (OUT_W < 1) begin : g_bad_geometry
    $error("conv_job_scheduler: kernel K must not exceed IMG_W");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [KW-1:0]       w_kr, w_kc, w_kr_n, w_kc_n;
  logic [PW-1:0]       w_pr, w_pc, w_pr_n, w_pc_n;
  logic                w_tap_last, w_pix_last;
  logic                w_load, w_accept, w_tap_en, w_pix_en;
  logic                w_abort_set, w_done_set, w_tmo;
  logic [1:0]          r_act_sel;
  logic [TW-1:0]       r_wait;
  logic                r_done, r_abort;
  logic [IN_AW-1:0]    r_in_addr;
  logic [W_AW-1:0]     r_w_addr;
  logic [OUT_AW-1:0]   r_out_addr;

  conv_tap_counter #(.N(K), .W(KW)) u_tap (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_accept),
    .i_en      (w_tap_en),
    .o_row     (w_kr),
    .o_col     (w_kc),
    .o_row_nxt (w_kr_n),
    .o_col_nxt (w_kc_n),
    .o_last    (w_tap_last)
  );

  conv_tap_counter #(.N(OUT_W), .W(PW)) u_pix (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_accept),
    .i_en      (w_pix_en),
    .o_row     (w_pr),
    .o_col     (w_pc),
    .o_row_nxt (w_pr_n),
    .o_col_nxt (w_pc_n),
    .o_last    (w_pix_last)
  );

  assign w_load = load_r || load_wr;
  assign w_tmo  = (r_wait == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A pending load outranks every handshake in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_tap_en    = 1'b0;
    w_pix_en    = 1'b0;
    w_abort_set = 1'b0;
    w_done_set  = 1'b0;
    mac_valid   = 1'b0;
    act_start   = 1'b0;
    out_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !w_load) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mac_valid = 1'b1;
        if (w_load) begin
          w_abort_set = 1'b1;
        end else if (mac_ready) begin
          w_tap_en = 1'b1;
          if (w_tap_last) w_state_nxt = S_WAIT_ACC;
        end
      end
      S_WAIT_ACC: begin
        if (w_load) begin
          w_abort_set = 1'b1;
        end else if (acc_valid) begin
          w_state_nxt = (r_act_sel == ACT_RELU || r_act_sel == ACT_CORDIC) ? S_ACT : S_WRITE;
        end else if (w_tmo) begin
          w_abort_set = 1'b1;
        end
      end
      S_ACT: begin
        act_start = (r_wait == '0);
        if (w_load) begin
          w_abort_set = 1'b1;
        end else if (act_done) begin
          w_state_nxt = S_WRITE;
        end else if (w_tmo) begin
          w_abort_set = 1'b1;
        end
      end
      S_WRITE: begin
        out_we = 1'b1;
        if (w_load) begin
          w_abort_set = 1'b1;
        end else if (w_pix_last) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_pix_en    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_FINISH: begin
        if (w_load) w_abort_set = 1'b1;
        else        w_done_set  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort_set) w_state_nxt = S_IDLE;
  end

  // done/abort are registered, so they are seen in the first IDLE cycle with busy already low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_sel  <= ACT_NONE;
      r_wait     <= '0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_in_addr  <= '0;
      r_w_addr   <= '0;
      r_out_addr <= '0;
    end else begin
      r_done  <= w_done_set;
      r_abort <= w_abort_set;
      if (w_accept) r_act_sel <= (act_mode == 2'b11) ? ACT_NONE : act_mode;
      if (w_state_nxt != r_state)       r_wait <= '0;
      else if (r_wait != TW'(TIMEOUT))  r_wait <= r_wait + TW'(1);
      // Address stage is fed from next-count values so it lines up with the counters.
      r_in_addr  <= IN_AW'((IN_AW'(w_pr_n) + IN_AW'(w_kr_n)) * IN_AW'(IMG_W)
                           + IN_AW'(w_pc_n) + IN_AW'(w_kc_n));
      r_w_addr   <= W_AW'(W_AW'(w_kr_n) * W_AW'(K) + W_AW'(w_kc_n));
      r_out_addr <= OUT_AW'(OUT_AW'(w_pr) * OUT_AW'(OUT_W) + OUT_AW'(w_pc));
    end
  end

  assign mac_first = (r_state == S_ISSUE) && (w_kr == '0) && (w_kc == '0);
  assign mac_last  = (r_state == S_ISSUE) && w_tap_last;
  assign in_addr   = r_in_addr;
  assign w_addr    = r_w_addr;
  assign out_addr  = r_out_addr;
  assign act_sel   = r_act_sel;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign abort     = r_abort;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler (IMG_W=6, K=5, TIMEOUT=255): four
// output pixels of 25 taps each, with MAC/accumulator/activation responders.
module tb_conv_job_scheduler;

  logic       clk = 1'b0;
  logic       reset, start, load_r, load_wr;
  logic [1:0] act_mode;
  logic       mac_ready, acc_valid, act_done;
  logic [5:0] in_addr;
  logic [4:0] w_addr;
  logic       mac_valid, mac_first, mac_last;
  logic [1:0] act_sel;
  logic       act_start, out_we;
  logic [1:0] out_addr;
  logic       busy, done, abort;

  int checks = 0;
  int passes = 0;
  int hs_cnt, we_cnt, done_cnt, abort_cnt, ast_cnt, ad_cnt, sel_bad;
  int load_cyc, abort_cyc, wait_entry, stall_seen;
  bit rst_hit;
  logic [5:0] got_in [7];

  conv_job_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .load_r    (load_r),
    .load_wr   (load_wr),
    .act_mode  (act_mode),
    .mac_ready (mac_ready),
    .acc_valid (acc_valid),
    .act_done  (act_done),
    .in_addr   (in_addr),
    .w_addr    (w_addr),
    .mac_valid (mac_valid),
    .mac_first (mac_first),
    .mac_last  (mac_last),
    .act_sel   (act_sel),
    .act_start (act_start),
    .out_we    (out_we),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  // Drives one job and reacts like the MAC / accumulator / activation engine.
  task automatic run_job(input logic [1:0] mode, input bit stall, input int act_delay,
                         input int load_at, input bit no_acc, input bit rst_in_act,
                         input int budget);
    int acc_t, act_t, stall_left, load_left, pix, t, pr, pc, kr, kc;
    logic [1:0] mode_exp;
    bit fin, do_rst;
    hs_cnt = 0; we_cnt = 0; done_cnt = 0; abort_cnt = 0; ast_cnt = 0; ad_cnt = 0;
    sel_bad = 0; load_cyc = -1; abort_cyc = -1; wait_entry = -1; stall_seen = 0; rst_hit = 0;
    acc_t = -1; act_t = -1; stall_left = stall ? 3 : 0; load_left = 0; fin = 0;
    mode_exp = (mode == 2'b11) ? 2'b00 : mode;
    act_mode = mode;
    for (int c = 0; c < budget && !fin; c++) begin
      do_rst = 0;
      start = (c == 0);
      if (load_at >= 0 && hs_cnt == load_at && mac_valid && load_cyc < 0) begin
        load_left = 2;
        load_cyc  = c;
      end
      load_wr = (load_left > 0);
      if (load_left > 0) start = 1'b1;
      mac_ready = !(stall_left > 0 && hs_cnt == 7 && mac_valid);
      acc_valid = !no_acc && (acc_t == 0);
      act_done  = (act_t == 0);
      if (act_done) ad_cnt++;
      if (busy && act_sel !== mode_exp) sel_bad++;
      if (mac_valid && !mac_ready) begin
        stall_left--;
        stall_seen++;
        checks++;
        if (in_addr !== 6'd8 || w_addr !== 5'd7)
          $display("FAIL stall_hold: in_addr=%0d w_addr=%0d, want 8/7", in_addr, w_addr);
        else passes++;
      end
      if (mac_valid && mac_ready && !load_wr) begin
        pix = hs_cnt / 25; t = hs_cnt % 25;
        pr = pix / 2; pc = pix % 2; kr = t / 5; kc = t % 5;
        checks++;
        if (in_addr !== 6'((pr + kr) * 6 + pc + kc) || w_addr !== 5'(kr * 5 + kc))
          $display("FAIL tap_addr[%0d]: in=%0d w=%0d, want in=%0d w=%0d", hs_cnt,
                   in_addr, w_addr, (pr + kr) * 6 + pc + kc, kr * 5 + kc);
        else passes++;
        checks++;
        if (mac_first !== (t == 0) || mac_last !== (t == 24))
          $display("FAIL tap_flags[%0d]: first=%0b last=%0b, want %0b/%0b", hs_cnt,
                   mac_first, mac_last, t == 0, t == 24);
        else passes++;
        if (hs_cnt < 7) got_in[hs_cnt] = in_addr;
        if (mac_last) begin
          acc_t = 2;
          wait_entry = c + 1;
        end
        hs_cnt++;
      end
      if (act_start) begin
        ast_cnt++;
        act_t = act_delay;
        if (rst_in_act) do_rst = 1;
      end
      if (out_we) begin
        checks++;
        if (out_addr !== 2'(we_cnt))
          $display("FAIL out_addr[%0d]: got %0d want %0d", we_cnt, out_addr, we_cnt);
        else passes++;
        if (mode_exp != 2'b00) begin
          checks++;
          if (ad_cnt !== we_cnt + 1)
            $display("FAIL write_after_act[%0d]: act_done seen %0d, want %0d", we_cnt, ad_cnt, we_cnt + 1);
          else passes++;
        end
        we_cnt++;
      end
      if (done || abort) begin
        if (done) done_cnt++;
        if (abort) begin
          abort_cnt++;
          abort_cyc = c;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_at_end: got %0b want 0", busy);
        else passes++;
        fin = 1;
      end
      if (do_rst) begin
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({in_addr, w_addr, mac_valid, mac_first, mac_last, act_sel, act_start, out_we,
             out_addr, busy, done, abort} !== '0)
          $display("FAIL reset_mid_act: outputs=%h want 0", {in_addr, w_addr, mac_valid,
                   mac_first, mac_last, act_sel, act_start, out_we, out_addr, busy, done, abort});
        else passes++;
        rst_hit = 1;
        fin = 1;
      end
      @(posedge clk); #1;
      if (acc_t >= 0) acc_t--;
      if (act_t >= 0) act_t--;
      if (load_left > 0) load_left--;
    end
    start = 0; load_wr = 0; mac_ready = 0; acc_valid = 0; act_done = 0;
    if (!fin) begin
      checks++;
      $display("FAIL job_budget: no done/abort within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 0; load_r = 0; load_wr = 0; act_mode = 0;
    mac_ready = 0; acc_valid = 0; act_done = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_addr, w_addr, mac_valid, mac_first, mac_last, act_sel, act_start, out_we,
         out_addr, busy, done, abort} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {in_addr, w_addr, mac_valid, mac_first,
               mac_last, act_sel, act_start, out_we, out_addr, busy, done, abort});
    else passes++;
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [5:0] exp_first [7];
    exp_first = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
    run_job(2'b00, 0, 0, -1, 0, 0, 2000);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got_in[i] !== exp_first[i])
        $display("FAIL first_seq[%0d]: got %0d want %0d", i, got_in[i], exp_first[i]);
      else passes++;
    end
    checks++;
    if (hs_cnt !== 100 || we_cnt !== 4 || done_cnt !== 1 || abort_cnt !== 0 || ast_cnt !== 0)
      $display("FAIL basic_counts: hs=%0d we=%0d done=%0d abort=%0d ast=%0d, want 100/4/1/0/0",
               hs_cnt, we_cnt, done_cnt, abort_cnt, ast_cnt);
    else passes++;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_pulse: done=%0b busy=%0b one cycle later, want 0/0", done, busy);
    else passes++;
  endtask

  task automatic test_stall();
    run_job(2'b00, 1, 0, -1, 0, 0, 2000);
    checks++;
    if (stall_seen !== 3 || hs_cnt !== 100 || we_cnt !== 4 || done_cnt !== 1)
      $display("FAIL stall_counts: stalls=%0d hs=%0d we=%0d done=%0d, want 3/100/4/1",
               stall_seen, hs_cnt, we_cnt, done_cnt);
    else passes++;
  endtask

  task automatic test_act_cordic();
    run_job(2'b10, 0, 10, -1, 0, 0, 3000);
    checks++;
    if (ast_cnt !== 4 || ad_cnt !== 4 || we_cnt !== 4 || done_cnt !== 1)
      $display("FAIL act_counts: ast=%0d ad=%0d we=%0d done=%0d, want 4/4/4/1",
               ast_cnt, ad_cnt, we_cnt, done_cnt);
    else passes++;
    checks++;
    if (sel_bad !== 0) $display("FAIL act_sel_held: %0d busy cycles with act_sel != 2", sel_bad);
    else passes++;
  endtask

  task automatic test_load_abort();
    int bad;
    run_job(2'b00, 0, 0, 30, 0, 0, 2000);
    checks++;
    if (abort_cnt !== 1 || abort_cyc - load_cyc !== 1 || we_cnt !== 1 || done_cnt !== 0)
      $display("FAIL load_abort: abort=%0d delay=%0d we=%0d done=%0d, want 1/1/1/0",
               abort_cnt, abort_cyc - load_cyc, we_cnt, done_cnt);
    else passes++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy || out_we || mac_valid || abort) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) $display("FAIL load_idle: %0d active cycles after abort, want 0", bad);
    else passes++;
  endtask

  task automatic test_timeout();
    run_job(2'b00, 0, 0, -1, 1, 0, 1000);
    checks++;
    if (abort_cnt !== 1 || abort_cyc - wait_entry !== 255 || we_cnt !== 0 || hs_cnt !== 25)
      $display("FAIL timeout: abort=%0d delay=%0d we=%0d hs=%0d, want 1/255/0/25",
               abort_cnt, abort_cyc - wait_entry, we_cnt, hs_cnt);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || abort !== 1'b0)
      $display("FAIL timeout_after: busy=%0b abort=%0b want 0/0", busy, abort);
    else passes++;
  endtask

  task automatic test_reset_mid_act();
    run_job(2'b01, 0, 10, -1, 0, 1, 2000);
    checks++;
    if (rst_hit !== 1'b1) $display("FAIL reset_reached: rst_hit=%0b want 1", rst_hit);
    else passes++;
    reset = 0;
    @(posedge clk); #1;
    run_job(2'b00, 0, 0, -1, 0, 0, 2000);
    checks++;
    if (hs_cnt !== 100 || we_cnt !== 4 || done_cnt !== 1 || abort_cnt !== 0)
      $display("FAIL rerun_counts: hs=%0d we=%0d done=%0d abort=%0d, want 100/4/1/0",
               hs_cnt, we_cnt, done_cnt, abort_cnt);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_act_cordic();
    test_load_abort();
    test_timeout();
    test_reset_mid_act();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
